// File: rtl/ones_word_gen_if.sv
// rtl/ones_word_gen_if.sv - request/result bundle for the ones word generator
interface ones_word_gen_if #(
  parameter int data_width  = 4,
  parameter int count_width = 3
);
  logic                   start;
  logic [count_width-1:0] count_in;
  logic [data_width-1:0]  data_out;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output start, count_in,
    input  data_out, busy, done, err
  );

  modport slave (
    input  start, count_in,
    output data_out, busy, done, err
  );
endinterface

// File: rtl/ones_word_gen.sv
// rtl/ones_word_gen.sv - builds a word with a requested number of ones, one bit per clock
module ones_word_gen #(
  parameter int data_width  = 4,
  parameter int count_width = 3
) (
  input  logic           clk,
  input  logic           reset,
  ones_word_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [count_width-1:0] max_count = count_width'(data_width);
  localparam logic [data_width-1:0]  lsb_one   = data_width'(1);

  state_t                 state_q, state_d;
  logic [data_width-1:0]  data_q, data_d;
  logic [count_width-1:0] index_q, index_d;
  logic [count_width-1:0] remaining_q, remaining_d;
  logic                   err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      index_q     <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      index_q     <= index_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    index_d     = index_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          data_d      = '0;
          index_d     = '0;
          err_d       = bus.count_in > max_count;
          remaining_d = err_d ? max_count : bus.count_in;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else begin
          // Shift instead of a bit-select so the index width never has to match data_width
          data_d      = data_q | (lsb_one << index_q);
          index_d     = index_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out = data_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_ones_word_gen.sv
// tb/tb_ones_word_gen.sv - self-checking bench for ones_word_gen
module tb_ones_word_gen;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ones_word_gen_if #(.data_width(4), .count_width(3)) bus ();

  ones_word_gen #(.data_width(4), .count_width(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int c);
    return (c > 4) ? 4 : c;
  endfunction

  function automatic logic [3:0] ones_word(input int n);
    return 4'((1 << n) - 1);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.count_in = '0;
    #10;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.data_out !== 4'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: data=%h busy=%b done=%b err=%b, want 0 0 0 0",
                 i, bus.data_out, bus.busy, bus.done, bus.err);
      end
    end
  endtask

  task automatic test_count(input int c);
    int k;
    logic [3:0] exp;
    k = sat(c);
    bus.start = 1'b1;
    bus.count_in = 3'(c);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.data_out !== 4'h0 || bus.err !== (c > 4)) begin
      failures++;
      $display("FAIL accept c=%0d: busy=%b data=%h err=%b, want 1 0 %b",
               c, bus.busy, bus.data_out, bus.err, c > 4);
    end
    for (int j = 1; j <= k + 1; j++) begin
      @(posedge clk);
      @(negedge clk);
      exp = ones_word((j <= k) ? j : k);
      checks++;
      if (bus.data_out !== exp || bus.done !== (j == k + 1) || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL fill c=%0d edge %0d: data=%h done=%b busy=%b, want %h %b 1",
                 c, j, bus.data_out, bus.done, bus.busy, exp, j == k + 1);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== ones_word(k) || bus.err !== (c > 4)) begin
      failures++;
      $display("FAIL after_done c=%0d: busy=%b done=%b data=%h err=%b, want 0 0 %h %b",
               c, bus.busy, bus.done, bus.data_out, bus.err, ones_word(k), c > 4);
    end
  endtask

  task automatic test_ignore_busy();
    int dones;
    dones = 0;
    bus.start = 1'b1;
    bus.count_in = 3'd2;
    @(posedge clk);
    @(negedge clk);
    bus.count_in = 3'd4;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 4) bus.start = 1'b0;
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1 || bus.data_out !== 4'h3 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_busy: dones=%0d data=%h busy=%b, want 1 3 0",
               dones, bus.data_out, bus.busy);
    end
  endtask

  task automatic test_reset_mid_fill();
    bus.start = 1'b1;
    bus.count_in = 3'd4;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.data_out !== 4'h3) begin
      failures++;
      $display("FAIL mid_fill_pre: data=%h, want 3", bus.data_out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.data_out !== 4'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: data=%h busy=%b done=%b, want 0 0 0",
               bus.data_out, bus.busy, bus.done);
    end
    @(negedge clk);
    reset = 1'b0;
    test_count(1);
  endtask

  task automatic test_random();
    int c, k, gap, edges;
    logic [3:0] prev_data;
    logic prev_err;
    bit seen;
    for (int it = 0; it < 25; it++) begin
      c = $urandom_range(0, 7);
      k = sat(c);
      gap = $urandom_range(0, 3);
      prev_data = bus.data_out;
      prev_err = bus.err;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        @(negedge clk);
      end
      checks++;
      if (bus.data_out !== prev_data || bus.err !== prev_err || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold it=%0d: data=%h err=%b busy=%b, want %h %b 0",
                 it, bus.data_out, bus.err, bus.busy, prev_data, prev_err);
      end
      bus.start = 1'b1;
      bus.count_in = 3'(c);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      edges = 0;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(posedge clk);
        @(negedge clk);
        edges++;
        if (bus.done === 1'b1) begin
          seen = 1'b1;
          bus.start = 1'b0;
        end else begin
          bus.start = 1'($urandom_range(0, 1));
          bus.count_in = 3'($urandom_range(0, 7));
        end
      end
      checks++;
      if (!seen || edges != k + 1 || bus.data_out !== ones_word(k) || bus.err !== (c > 4)) begin
        failures++;
        $display("FAIL random it=%0d c=%0d: seen=%b edges=%0d data=%h err=%b, want 1 %0d %h %b",
                 it, c, seen, edges, bus.data_out, bus.err, k + 1, ones_word(k), c > 4);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL random_idle it=%0d: busy=%b done=%b, want 0 0", it, bus.busy, bus.done);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_count(3);
    test_count(0);
    test_count(4);
    test_count(7);
    test_count(2);
    test_ignore_busy();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ones_word_gen.md
Name: ones_word_gen

Overview:
- Sequential inverse of the ones-counter blocks: takes a requested population count and builds a data_width-bit word with exactly that many ones, packed from bit 0 upward.
- Builds the word one bit per clock using a multi-cycle loop with embedded timing. It does not produce the word combinationally in one cycle.
- Sits upstream of a ones counter as a stimulus/pattern source. Its data_out fed into a ones counter must reproduce count_in.

Parameters:
- data_width, 4, width of generated word.
- count_width, 3, width of count_in. Must satisfy 2**count_width > data_width.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse. Sampled on posedge, honoured only in IDLE.
- count_in  input  count_width  requested number of ones. Sampled with an accepted start.
- data_out  output  data_width  generated word. Registered.
- busy  output  1  high in FILL and DONE states.
- done  output  1  high for exactly one cycle when the word is complete.
- err  output  1  request exceeded data_width and was saturated.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - data_out = 0, busy = 0, done = 0, err = 0.
  - Internal index = 0, remaining = 0.
- Reset asserted mid-operation: all of the above take effect immediately, without waiting for clk. The partial word is discarded.
- State machine: IDLE, FILL, DONE. busy = (state != IDLE). done = (state == DONE). Both are decoded from registered state, so they are glitch-free.
- IDLE:
  - Without start: hold data_out, err, and all state.
  - On posedge with start = 1:
    - Clear data_out to 0 and set index = 0.
    - remaining = min(count_in, data_width).
    - err = 1 if count_in > data_width, else 0.
    - Go to FILL.
- FILL, each posedge:
  - If remaining == 0: go to DONE, data_out unchanged.
  - Else: data_out[index] <= 1, index <= index + 1, remaining <= remaining - 1. Stay in FILL.
- DONE: one cycle only, then unconditionally back to IDLE. data_out holds its final value.
- Latency:
  - Start accepted at edge 0; bits set at edges 1..k; done rises after edge k+1.
  - Exactly k+1 edges from start to done, where k = saturated count.
  - k = 0 gives done after edge 1 with data_out = 0.
- Handshake:
  - start while busy (FILL or DONE) is ignored. No queuing, and count_in is not re-sampled.
  - start in the same cycle done is high is ignored. Upstream must wait for busy = 0.
- Word format:
  - Final data_out = (1 << k) - 1, i.e. ones packed from the LSB.
  - data_out bits above index are never written during FILL.
- Widths:
  - index and remaining are count_width bits.
  - Saturation compare is performed at count_width width. No truncation, since 2**count_width > data_width.
- Hold rules:
  - data_out and err hold across IDLE until the next accepted start.
  - done never asserts for more than one cycle.

Test Plan:
- Reset then idle: reset high 10 ns, release, no start -> data_out = 4'h0, busy = 0, done = 0, err = 0 for 5 cycles.
- count_in = 3, start pulse:
  - data_out steps 4'h1, 4'h3, 4'h7 on successive edges.
  - done pulses high one cycle after the 4'h7 edge, 4 edges after start.
  - err = 0, busy low again the following cycle.
- count_in = 0 and count_in = 4:
  - count_in = 0 -> done after 1 edge with data_out = 4'h0.
  - count_in = 4 -> data_out 4'h1, 4'h3, 4'h7, 4'hF, done after 5 edges.
- Saturation: count_in = 7 -> data_out = 4'hF, err = 1, done after 5 edges. A following count_in = 2 request clears err and gives 4'h3.
- start ignored while busy: start with count_in = 2, then start with count_in = 4 on the next two edges -> final data_out = 4'h3, a single done pulse, no second run.
- Reset mid-FILL: count_in = 4, assert reset asynchronously after data_out = 4'h3 -> data_out = 0 and busy = 0 immediately. After release, a count_in = 1 request yields 4'h1.
